// File: rtl/nes_pad_reader.sv
// Multi-pad NES/SNES serial game-pad reader: one shared latch/clock pair, up to four pads in parallel.
// Optional newly-pressed edge detection on o_pressed is built when NES_PAD_EDGE_EN is defined.
module nes_pad_reader #(
  parameter int CYCLES_PER_PULSE = 150,
  parameter int NUM_BITS         = 8,
  parameter int NUM_PADS         = 1
) (
  input  logic                         clk,
  input  logic                         i_rst_n,
  input  logic                         i_read_buttons,
  output logic                         o_busy,
  output logic                         o_valid,
  output logic [NUM_PADS*NUM_BITS-1:0] o_buttons,
  output logic [NUM_PADS*NUM_BITS-1:0] o_pressed,
  input  logic [NUM_PADS-1:0]          i_controller_data,
  output logic                         o_controller_latch,
  output logic                         o_controller_clock
);

  localparam int W     = NUM_PADS * NUM_BITS;
  localparam int CNT_W = $clog2(2 * CYCLES_PER_PULSE);
  localparam int BIT_W = $clog2(NUM_BITS);

  localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(CYCLES_PER_PULSE - 1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'((3 * CYCLES_PER_PULSE) / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_END    = CNT_W'(2 * CYCLES_PER_PULSE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(NUM_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [W-1:0]     sr;

  // Every pad shifts its inverted serial bit in at the LSB; the first bit ends at the MSB.
  function automatic logic [W-1:0] shift_in(input logic [W-1:0] cur,
                                            input logic [NUM_PADS-1:0] din);
    logic [W-1:0] nxt;
    nxt = cur;
    for (int p = 0; p < NUM_PADS; p++) begin
      nxt[p*NUM_BITS +: NUM_BITS] = {cur[p*NUM_BITS +: NUM_BITS-1], ~din[p]};
    end
    return nxt;
  endfunction

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state              <= IDLE;
      cnt                <= '0;
      bit_cnt            <= '0;
      sr                 <= '0;
      o_buttons          <= '0;
      o_valid            <= 1'b0;
      o_busy             <= 1'b0;
      o_controller_latch <= 1'b0;
      o_controller_clock <= 1'b1;
`ifdef NES_PAD_EDGE_EN
      o_pressed          <= '0;
`endif
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_read_buttons) begin
            state              <= LATCH;
            cnt                <= '0;
            o_controller_latch <= 1'b1;
            o_busy             <= 1'b1;
          end
        end
        LATCH: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_HALF) o_controller_latch <= 1'b0;
          if (cnt == CNT_SAMPLE) sr <= shift_in(sr, i_controller_data);
          if (cnt == CNT_END) begin
            state              <= SHIFT;
            bit_cnt            <= BIT_W'(1);
            cnt                <= '0;
            o_controller_clock <= 1'b0;
          end
        end
        SHIFT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_HALF) o_controller_clock <= 1'b1;
          if (cnt == CNT_SAMPLE) sr <= shift_in(sr, i_controller_data);
          if (cnt == CNT_END) begin
            if (bit_cnt == BIT_LAST) begin
              // Results are registered on entry so they are visible during the DONE cycle.
              state     <= DONE;
              o_buttons <= sr;
              o_valid   <= 1'b1;
`ifdef NES_PAD_EDGE_EN
              o_pressed <= sr & ~o_buttons;
`endif
            end else begin
              bit_cnt            <= bit_cnt + 1'b1;
              cnt                <= '0;
              o_controller_clock <= 1'b0;
            end
          end
        end
        DONE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef NES_PAD_EDGE_EN
  assign o_pressed = '0;
`endif

endmodule

// File: tb/tb_nes_pad_reader.sv
// Directed bench for nes_pad_reader: an NES single-pad instance and an SNES dual-pad instance,
// each driven by a behavioural shift-register pad model.
module tb_nes_pad_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  // NES instance: P=4, 8 bits, 1 pad
  logic        req_a = 1'b0;
  logic        busy_a, valid_a, latch_a, clock_a;
  logic [7:0]  buttons_a, pressed_a;
  logic [0:0]  data_a;
  logic [7:0]  word_a = 8'h00;
  int          idx_a = 99;
  logic        clk_prev_a = 1'b1;

  // SNES instance: P=4, 16 bits, 2 pads
  logic        req_b = 1'b0;
  logic        busy_b, valid_b, latch_b, clock_b;
  logic [31:0] buttons_b, pressed_b;
  logic [1:0]  data_b;
  logic [15:0] word_b0 = 16'h0000;
  logic [15:0] word_b1 = 16'h0000;
  int          idx_b = 99;
  logic        clk_prev_b = 1'b1;

  nes_pad_reader #(.CYCLES_PER_PULSE(4), .NUM_BITS(8), .NUM_PADS(1)) dut_a (
    .clk(clk), .i_rst_n(rst_n), .i_read_buttons(req_a),
    .o_busy(busy_a), .o_valid(valid_a), .o_buttons(buttons_a), .o_pressed(pressed_a),
    .i_controller_data(data_a), .o_controller_latch(latch_a), .o_controller_clock(clock_a));

  nes_pad_reader #(.CYCLES_PER_PULSE(4), .NUM_BITS(16), .NUM_PADS(2)) dut_b (
    .clk(clk), .i_rst_n(rst_n), .i_read_buttons(req_b),
    .o_busy(busy_b), .o_valid(valid_b), .o_buttons(buttons_b), .o_pressed(pressed_b),
    .i_controller_data(data_b), .o_controller_latch(latch_b), .o_controller_clock(clock_b));

  // Pad model: latch reloads bit 0, each rising pad clock advances one bit; pressed = low.
  always @(posedge clk) begin
    if (latch_a) idx_a <= 0;
    else if (clock_a && !clk_prev_a) idx_a <= idx_a + 1;
    clk_prev_a <= clock_a;
    if (latch_b) idx_b <= 0;
    else if (clock_b && !clk_prev_b) idx_b <= idx_b + 1;
    clk_prev_b <= clock_b;
  end

  always_comb begin
    data_a = 1'b1;
    data_b = 2'b11;
    if (idx_a < 8) data_a[0] = ~word_a[7 - idx_a];
    if (idx_b < 16) begin
      data_b[0] = ~word_b0[15 - idx_b];
      data_b[1] = ~word_b1[15 - idx_b];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-run observations of dut_a
  int   first_valid, nvalid, err_latch, err_clk, err_busy, npulse, badlen;
  logic snap_latch, snap_clock, snap_busy;
  logic [7:0] snap_buttons;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Request during cycle 0; optional re-requests and a one-cycle reset at given cycles.
  task automatic run_a(input int ncyc, input int rep1, input int rep2, input int rst_at);
    int   lowlen;
    logic prev_clk;
    logic exp_latch, exp_clk, exp_busy;
    first_valid = -1; nvalid = 0; err_latch = 0; err_clk = 0; err_busy = 0;
    npulse = 0; badlen = 0; lowlen = 0; prev_clk = 1'b1;
    req_a = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      exp_latch = (c >= 1 && c <= 4);
      exp_clk   = !(c >= 9 && c <= 60 && ((c - 1) % 8) <= 3);
      exp_busy  = (c >= 1 && c <= 65);
      if (latch_a !== exp_latch) err_latch++;
      if (clock_a !== exp_clk) err_clk++;
      if (busy_a !== exp_busy) err_busy++;
      if (prev_clk && !clock_a) begin npulse++; lowlen = 0; end
      if (!clock_a) lowlen++;
      if (!prev_clk && clock_a && lowlen != 4) badlen++;
      prev_clk = clock_a;
      if (valid_a) begin
        nvalid++;
        if (first_valid < 0) first_valid = c;
      end
      if (c == rst_at + 1) begin
        snap_latch = latch_a; snap_clock = clock_a; snap_busy = busy_a; snap_buttons = buttons_a;
      end
      req_a = (c == rep1 || c == rep2);
      rst_n = !(c == rst_at);
    end
    req_a = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    int   vcyc[$];
    int   errstab;
    int   fvb;
    logic [7:0] expb;
    logic [7:0] pwords[3];
    logic [7:0] pexp[3];

    // Reset state
    idle(3);
    check("rst_latch", latch_a, 1'b0);
    check("rst_clock", clock_a, 1'b1);
    check("rst_busy", busy_a, 1'b0);
    check("rst_valid", valid_a, 1'b0);
    check("rst_buttons", buttons_a, 8'h00);
    check("rst_pressed", pressed_a, 8'h00);
    rst_n = 1'b1;
    idle(3);

    // NES poll: A and Right pressed
    word_a = 8'h81;
    run_a(70, -1, -1, -1);
    check("nes_latch_wave", err_latch, 0);
    check("nes_clock_wave", err_clk, 0);
    check("nes_busy_wave", err_busy, 0);
    check("nes_clk_pulses", npulse, 7);
    check("nes_clk_lowlen", badlen, 0);
    check("nes_valid_cycle", first_valid, 65);
    check("nes_valid_count", nvalid, 1);
    check("nes_buttons", buttons_a, 8'h81);
    idle(3);

    // SNES dual pad: pad0 B, pad1 R
    word_b0 = 16'h8000;
    word_b1 = 16'h0010;
    fvb = -1;
    req_b = 1'b1;
    for (int c = 1; c <= 140; c++) begin
      @(negedge clk);
      req_b = 1'b0;
      if (valid_b && fvb < 0) fvb = c;
    end
    check("snes_valid_cycle", fvb, 129);
    check("snes_buttons", buttons_b, 32'h0010_8000);
    idle(3);

    // Mid-poll re-requests are ignored
    word_a = 8'h81;
    run_a(80, 10, 30, -1);
    check("rereq_valid_count", nvalid, 1);
    check("rereq_valid_cycle", first_valid, 65);
    check("rereq_busy_wave", err_busy, 0);
    idle(3);

    // Reset mid-poll at cycle 20
    word_a = 8'h24;
    run_a(80, -1, -1, 20);
    check("midrst_latch", snap_latch, 1'b0);
    check("midrst_clock", snap_clock, 1'b1);
    check("midrst_busy", snap_busy, 1'b0);
    check("midrst_buttons", snap_buttons, 8'h00);
    check("midrst_no_valid", nvalid, 0);
    idle(3);
    word_a = 8'h3C;
    run_a(70, -1, -1, -1);
    check("postrst_valid_cycle", first_valid, 65);
    check("postrst_buttons", buttons_a, 8'h3C);
    idle(3);

    // Request held high: back-to-back polls
    word_a = 8'h42;
    errstab = 0;
    req_a = 1'b1;
    for (int c = 1; c <= 140; c++) begin
      @(negedge clk);
      if (valid_a) vcyc.push_back(c);
      expb = (c < 65) ? 8'h3C : (c < 131) ? 8'h42 : 8'h18;
      if (buttons_a !== expb) errstab++;
      if (c == 65) word_a = 8'h18;
    end
    req_a = 1'b0;
    check("hold_valid_count", vcyc.size(), 2);
    if (vcyc.size() >= 2) begin
      check("hold_valid_first", vcyc[0], 65);
      check("hold_valid_second", vcyc[1], 131);
    end
    check("hold_buttons_stable", errstab, 0);
    begin
      int waited = 0;
      while (busy_a === 1'b1 && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      check("hold_drain_timeout", busy_a, 1'b0);
    end
    idle(3);

    // Newly-pressed detection over three polls
    pwords[0] = 8'h00; pwords[1] = 8'h80; pwords[2] = 8'h80;
`ifdef NES_PAD_EDGE_EN
    pexp[0] = 8'h00; pexp[1] = 8'h80; pexp[2] = 8'h00;
`else
    pexp[0] = 8'h00; pexp[1] = 8'h00; pexp[2] = 8'h00;
`endif
    for (int i = 0; i < 3; i++) begin
      word_a = pwords[i];
      run_a(70, -1, -1, -1);
      check($sformatf("pressed_poll%0d", i + 1), pressed_a, pexp[i]);
      check($sformatf("pressed_buttons%0d", i + 1), buttons_a, pwords[i]);
      idle(3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nes_pad_reader.md
# nes_pad_reader

Parametrised serial game-pad reader. It drives one shared latch/clock pair and samples up to four pads in parallel. Pads can be NES (8-bit) or SNES (16-bit) shift-register style. It replaces single-pad reading in designs that need multiple players or SNES pads. It sits between the pad connector pins and game logic: game logic requests a poll, and the block returns one `o_valid` pulse with all button words.

## Interface
Parameters:
- `CYCLES_PER_PULSE`, default 150: `clk` cycles per latch/clock half-period. Must be ≥ 2.
- `NUM_BITS`, default 8: bits shifted per pad. Must be 8 (NES) or 16 (SNES).
- `NUM_PADS`, default 1: pads sampled in parallel. Range 1..4.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock.
- `i_rst_n`  in  1  synchronous active-low reset.
- `i_read_buttons`  in  1  poll request. Sampled only in IDLE.
- `o_busy`  out  1  high from the cycle after a request is accepted through DONE.
- `o_valid`  out  1  one-cycle pulse when `o_buttons` is updated.
- `o_buttons`  out  NUM_PADS*NUM_BITS  button words, active-high. Pad p occupies [p*NUM_BITS +: NUM_BITS].
- `o_pressed`  out  NUM_PADS*NUM_BITS  newly-pressed bits. See Configuration.
- `i_controller_data`  in  NUM_PADS  serial data from the pads, active-low. Bit p belongs to pad p.
- `o_controller_latch`  out  1  shared latch, active-high.
- `o_controller_clock`  out  1  shared clock, idle high.

## Operation
- States: IDLE, LATCH, SHIFT, DONE. The counter is $clog2(2*CYCLES_PER_PULSE) bits wide, and a bit counter is $clog2(NUM_BITS) bits wide.
- IDLE: latch is 0 and clock is 1. If `i_read_buttons` is 1, the block goes to LATCH, clears the counter, and sets latch to 1.
- LATCH, covering count 0..2P-1 (P = CYCLES_PER_PULSE):
  - At count P-1, latch goes to 0.
  - At count 3P/2-1 (integer division), the first bit is sampled.
  - At count 2P-1, the block goes to SHIFT, sets bit count to 1, and sets clock to 0.
- SHIFT, one bit period per bit:
  - At count P-1, clock goes to 1.
  - At count 3P/2-1, every pad is sampled.
  - At count 2P-1: if bit count equals NUM_BITS-1, go to DONE. Otherwise increment bit count, clear the counter, and set clock to 0.
- Sampling: each pad's internal shift register takes `{sr[NUM_BITS-2:0], ~i_controller_data[p]}`. The first serial bit (A / B on SNES) ends in bit NUM_BITS-1.
- DONE (one cycle):
  - Copy the shift registers to `o_buttons`.
  - Pulse `o_valid`.
  - Update `o_pressed` when the macro is enabled.
  - Return to IDLE.
- `o_buttons` holds its last valid value between polls. It is never cleared by a poll in progress.
- `i_read_buttons` is ignored while `o_busy` is high. A request held high across DONE starts a new poll on the first IDLE cycle, so back-to-back polling is allowed.
- Reset at any point, including mid-poll:
  - state → IDLE.
  - `o_controller_latch` = 0, `o_controller_clock` = 1.
  - `o_valid` = 0, `o_busy` = 0.
  - `o_buttons` = 0, `o_pressed` = 0, shift registers = 0.
  - previous-buttons register = 0.

## Timing
- All outputs are registered.
- With request accepted at cycle t:
  - latch is high over t+1 .. t+P.
  - o_busy is high over t+1 .. t+2P·NUM_BITS+1.
  - o_valid is high at cycle t+1+2P·NUM_BITS only.
- Bit k (k ≥ 1) bit period: clock is low over t+1+2Pk .. t+2Pk+P and high for the following P cycles.
- Sample instants fall at the midpoint of the high phase. Data is therefore sampled P/2 cycles after the rising clock edge (or after the latch fall for bit 0).
- Minimum poll-to-poll interval is 2P·NUM_BITS+2 cycles.

## Configuration
- `NES_PAD_EDGE_EN` defined:
  - At DONE, `o_pressed` = new `o_buttons` & ~previous `o_buttons`.
  - `o_pressed` holds until the next DONE.
  - Previous is the value of `o_buttons` before this update.
- Not defined: `o_pressed` is tied to 0, and no previous-buttons register is built.

## Test plan
- P=4, NUM_BITS=8, NUM_PADS=1:
  - Stimulus: pulse request at cycle 0; pad data pattern A..Right = 0,1,1,1,1,1,1,0 (active-low).
  - Required response: latch high for cycles 1-4; 7 clock-low pulses of 4 cycles; o_valid only at cycle 65; o_buttons = 8'h81.
- NUM_PADS=2, NUM_BITS=16:
  - Stimulus: pad0 presses B only; pad1 presses R only.
  - Required response: o_buttons = {16'h0010, 16'h8000}; o_valid at cycle 1+32P.
- Stimulus: request pulsed again at mid-poll cycles 10 and 30.
  - Required response: ignored; exactly one o_valid; o_busy continuous.
- Stimulus: i_rst_n low for 1 cycle at cycle 20 of a poll.
  - Required response: next cycle latch=0, clock=1, o_busy=0, o_buttons=0; no o_valid. A new request then completes normally.
- Stimulus: request held high constantly.
  - Required response: o_valid pulses every 2P·NUM_BITS+2 cycles; o_buttons stable between pulses.
- With NES_PAD_EDGE_EN, NUM_BITS=8:
  - Stimulus: three polls with A pressed on polls 2 and 3.
  - Required response: o_pressed = 8'h00, 8'h80, 8'h00 respectively.
  - Without the macro, o_pressed is always 0.
